// File: rtl/game_irq_scheduler.sv
// game_irq_scheduler
//   Merges the game interrupt sources (level-dependent tick, collision,
//   button press) onto the single KCPSM6 interrupt line. Each source latches
//   a pending cause. The firmware reads the causes, masks them through a
//   writable enable register, and clears them with a write-1-to-clear port.
//   A write to the clear port also marks the end of the service routine.
//
// Ports:
//   clk, rst       system clock, synchronous active-high reset
//   level_fast     selects the fast tick period
//   collision      collision level from the video datapath
//   db_btns[3:0]   debounced buttons
//   port_id[7:0]   KCPSM6 port address
//   out_port[7:0]  KCPSM6 write data
//   write_strobe   KCPSM6 write strobe
//   interrupt_ack  KCPSM6 interrupt acknowledge
//   interrupt      KCPSM6 interrupt request (registered)
//   irq_cause[7:0] pending causes: bit0 tick, bit1 collision, bit2 button
//   irq_mask[7:0]  enable mask; only bits 2:0 gate the request
module game_irq_scheduler #(
    parameter int         TICK_SLOW = 10000000,
    parameter int         TICK_FAST = 4000000,
    parameter int         CNT_W     = 26,
    parameter logic [7:0] MASK_PORT = 8'h0A,
    parameter logic [7:0] CLR_PORT  = 8'h0B
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       level_fast,
    input  logic       collision,
    input  logic [3:0] db_btns,
    input  logic [7:0] port_id,
    input  logic [7:0] out_port,
    input  logic       write_strobe,
    input  logic       interrupt_ack,
    output logic       interrupt,
    output logic [7:0] irq_cause,
    output logic [7:0] irq_mask
);

    typedef enum logic [1:0] {IDLE, REQ, SERVICE} state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, period;
    logic             tick;
    logic             coll_q;
    logic [3:0]       btn_q;
    logic [2:0]       pend, set_v, clr_v;
    logic             mask_wr, clr_wr;

    // Tick counter: one tick per period+1 cycles. A count beyond the period
    // can only follow a switch to the shorter period; it restarts at zero
    // without producing a tick.
    assign period = level_fast ? CNT_W'(TICK_FAST) : CNT_W'(TICK_SLOW);
    assign tick   = (cnt == period);

    always_ff @(posedge clk) begin
        if (rst)                cnt <= '0;
        else if (cnt >= period) cnt <= '0;
        else                    cnt <= cnt + 1'b1;
    end

    // Edge detectors; simultaneous button edges collapse into one set.
    always_ff @(posedge clk) begin
        if (rst) begin
            coll_q <= 1'b0;
            btn_q  <= 4'b0;
        end else begin
            coll_q <= collision;
            btn_q  <= db_btns;
        end
    end

    assign mask_wr = write_strobe && (port_id == MASK_PORT);
    assign clr_wr  = write_strobe && (port_id == CLR_PORT);

    assign set_v = {|(db_btns & ~btn_q), collision & ~coll_q, tick};
    assign clr_v = clr_wr ? out_port[2:0] : 3'b000;

    // Pending causes latch regardless of the mask; a set in the same cycle
    // as its clear wins so no event is lost.
    always_ff @(posedge clk) begin
        if (rst) pend <= 3'b000;
        else     pend <= (pend & ~clr_v) | set_v;
    end

    always_ff @(posedge clk) begin
        if (rst)          irq_mask <= 8'h03;
        else if (mask_wr) irq_mask <= out_port;
    end

    assign irq_cause = {5'b0, pend};

    // Request FSM. SERVICE holds off new requests until the ISR signals its
    // end through the clear port; events arriving meanwhile stay pending and
    // are requested from IDLE, which guarantees a low cycle between requests.
    // Once raised, a request is never retracted by a mask change.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if ((pend & irq_mask[2:0]) != 3'b000) state_nxt = REQ;
            REQ:     if (interrupt_ack)                    state_nxt = SERVICE;
            SERVICE: if (clr_wr)                           state_nxt = IDLE;
            default:                                       state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            interrupt <= 1'b0;
        end else begin
            state     <= state_nxt;
            interrupt <= (state_nxt == REQ);
        end
    end

endmodule

// File: tb/tb_game_irq_scheduler.sv
// Directed bench for game_irq_scheduler with short tick periods
// (slow 10, fast 4). Edge numbers below count rising clock edges after the
// reset release; outputs are sampled 1 time unit after each edge.
module tb_game_irq_scheduler;

    localparam logic [7:0] MP = 8'h0A;
    localparam logic [7:0] CP = 8'h0B;

    logic       clk = 1'b0;
    logic       rst;
    logic       level_fast, collision, write_strobe, interrupt_ack;
    logic [3:0] db_btns;
    logic [7:0] port_id, out_port;
    logic       interrupt;
    logic [7:0] irq_cause, irq_mask;

    int checks = 0;
    int errors = 0;

    game_irq_scheduler #(
        .TICK_SLOW(10), .TICK_FAST(4), .CNT_W(26), .MASK_PORT(MP), .CLR_PORT(CP)
    ) dut (
        .clk(clk), .rst(rst), .level_fast(level_fast), .collision(collision),
        .db_btns(db_btns), .port_id(port_id), .out_port(out_port),
        .write_strobe(write_strobe), .interrupt_ack(interrupt_ack),
        .interrupt(interrupt), .irq_cause(irq_cause), .irq_mask(irq_mask)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       lf;
        logic       coll;
        logic [3:0] btns;
        logic [7:0] pid;
        logic [7:0] dat;
        logic       ws;
        logic       ack;
        logic       e_int;
        logic [7:0] e_cause;
        logic [7:0] e_mask;
    } vec_t;

    vec_t vecs [22];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_in();
        level_fast = 1'b0; collision = 1'b0; db_btns = 4'h0;
        port_id = 8'h00; out_port = 8'h00; write_strobe = 1'b0; interrupt_ack = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        clr_in();
        step();
        step();
        rst = 1'b0;
    endtask

    initial begin
        // e1..e22 after a fresh reset; tick edges fall at 11 and 22.
        //            lf coll btns  pid  dat  ws ack  int cause mask
        vecs[0]  = '{1'b0,1'b0,4'h0,8'h00,8'h00,1'b0,1'b0, 1'b0,8'h00,8'h03};
        vecs[1]  = '{1'b0,1'b1,4'h0,8'h00,8'h00,1'b0,1'b0, 1'b0,8'h02,8'h03}; // collision edge
        vecs[2]  = '{1'b0,1'b1,4'h0,8'h00,8'h00,1'b0,1'b0, 1'b1,8'h02,8'h03}; // request
        vecs[3]  = '{1'b0,1'b1,4'h0,8'h00,8'h00,1'b0,1'b0, 1'b1,8'h02,8'h03};
        vecs[4]  = '{1'b0,1'b0,4'h0,8'h00,8'h00,1'b0,1'b1, 1'b0,8'h02,8'h03}; // ack
        vecs[5]  = '{1'b0,1'b0,4'h0,8'h00,8'h00,1'b0,1'b1, 1'b0,8'h02,8'h03}; // ack in SERVICE ignored
        vecs[6]  = '{1'b0,1'b0,4'h0,CP,   8'h02,1'b1,1'b0, 1'b0,8'h00,8'h03}; // clear, end of ISR
        vecs[7]  = '{1'b0,1'b1,4'h0,8'h00,8'h00,1'b0,1'b0, 1'b0,8'h02,8'h03}; // second collision
        vecs[8]  = '{1'b0,1'b1,4'h0,MP,   8'h00,1'b1,1'b0, 1'b1,8'h02,8'h00}; // mask off as REQ starts
        vecs[9]  = '{1'b0,1'b1,4'h0,8'h00,8'h00,1'b0,1'b0, 1'b1,8'h02,8'h00}; // no retraction
        vecs[10] = '{1'b0,1'b1,4'h0,8'h00,8'h00,1'b0,1'b0, 1'b1,8'h03,8'h00}; // tick
        vecs[11] = '{1'b0,1'b1,4'h0,8'h00,8'h00,1'b0,1'b1, 1'b0,8'h03,8'h00}; // ack
        vecs[12] = '{1'b0,1'b0,4'h0,CP,   8'h07,1'b1,1'b0, 1'b0,8'h00,8'h00}; // clear all
        vecs[13] = '{1'b0,1'b0,4'h1,8'h00,8'h00,1'b0,1'b0, 1'b0,8'h04,8'h00}; // button, masked
        vecs[14] = '{1'b0,1'b0,4'h3,8'h00,8'h00,1'b0,1'b0, 1'b0,8'h04,8'h00};
        vecs[15] = '{1'b0,1'b0,4'h0,8'h00,8'h00,1'b0,1'b0, 1'b0,8'h04,8'h00};
        vecs[16] = '{1'b0,1'b0,4'h0,MP,   8'h04,1'b1,1'b0, 1'b0,8'h04,8'h04}; // unmask button
        vecs[17] = '{1'b0,1'b0,4'h0,8'h00,8'h00,1'b0,1'b0, 1'b1,8'h04,8'h04};
        vecs[18] = '{1'b0,1'b0,4'h0,8'h00,8'h00,1'b0,1'b1, 1'b0,8'h04,8'h04}; // ack
        vecs[19] = '{1'b0,1'b1,4'h0,CP,   8'h02,1'b1,1'b0, 1'b0,8'h06,8'h04}; // set beats clear
        vecs[20] = '{1'b0,1'b1,4'h0,8'h00,8'h00,1'b0,1'b0, 1'b1,8'h06,8'h04};
        vecs[21] = '{1'b0,1'b1,4'h0,8'h00,8'h00,1'b0,1'b0, 1'b1,8'h07,8'h04}; // tick in REQ

        // Reset state
        do_reset();
        chk("reset_interrupt", {31'b0, interrupt}, 32'h0);
        chk("reset_cause", {24'b0, irq_cause}, 32'h00);
        chk("reset_mask", {24'b0, irq_mask}, 32'h03);

        // Table
        for (int i = 0; i < 22; i++) begin
            level_fast = vecs[i].lf; collision = vecs[i].coll; db_btns = vecs[i].btns;
            port_id = vecs[i].pid; out_port = vecs[i].dat;
            write_strobe = vecs[i].ws; interrupt_ack = vecs[i].ack;
            step();
            chk($sformatf("vec%0d_interrupt", i + 1), {31'b0, interrupt}, {31'b0, vecs[i].e_int});
            chk($sformatf("vec%0d_cause", i + 1), {24'b0, irq_cause}, {24'b0, vecs[i].e_cause});
            chk($sformatf("vec%0d_mask", i + 1), {24'b0, irq_mask}, {24'b0, vecs[i].e_mask});
        end

        // Reset while in REQ
        rst = 1'b1;
        clr_in();
        step();
        chk("rst_req_interrupt", {31'b0, interrupt}, 32'h0);
        chk("rst_req_cause", {24'b0, irq_cause}, 32'h00);
        chk("rst_req_mask", {24'b0, irq_mask}, 32'h03);
        rst = 1'b0;

        // Slow tick timing: pend at 11, request at 12, held without ack.
        // An ack at edge 5 arrives in IDLE and must be ignored.
        do_reset();
        for (int e = 1; e <= 15; e++) begin
            interrupt_ack = (e == 5);
            step();
            chk($sformatf("slow_e%0d_cause", e), {24'b0, irq_cause}, (e >= 11) ? 32'h01 : 32'h00);
            chk($sformatf("slow_e%0d_int", e), {31'b0, interrupt}, (e >= 12) ? 32'h1 : 32'h0);
        end
        interrupt_ack = 1'b1;
        step();                                       // e16
        interrupt_ack = 1'b0;
        chk("slow_ack_int", {31'b0, interrupt}, 32'h0);
        chk("slow_ack_cause", {24'b0, irq_cause}, 32'h01);
        port_id = CP; out_port = 8'h01; write_strobe = 1'b1;
        step();                                       // e17
        write_strobe = 1'b0; port_id = 8'h00; out_port = 8'h00;
        chk("slow_clr_cause", {24'b0, irq_cause}, 32'h00);
        chk("slow_clr_int", {31'b0, interrupt}, 32'h0);
        for (int e = 18; e <= 23; e++) begin
            step();
            chk($sformatf("slow_e%0d_cause", e), {24'b0, irq_cause}, (e >= 22) ? 32'h01 : 32'h00);
            chk($sformatf("slow_e%0d_int", e), {31'b0, interrupt}, (e >= 23) ? 32'h1 : 32'h0);
        end

        // Switch to the fast period at count 7: restart without a tick,
        // then ticks at edges 13, 18, 23, each cleared on the next edge.
        do_reset();
        for (int e = 1; e <= 7; e++) step();
        level_fast = 1'b1;
        for (int e = 8; e <= 23; e++) begin
            if (e == 14 || e == 19) begin
                port_id = CP; out_port = 8'h01; write_strobe = 1'b1;
            end else begin
                port_id = 8'h00; out_port = 8'h00; write_strobe = 1'b0;
            end
            step();
            chk($sformatf("fast_e%0d_tick", e), {31'b0, irq_cause[0]},
                (e == 13 || e == 18 || e == 23) ? 32'h1 : 32'h0);
        end

        // Collision held high for 20 cycles sets exactly once.
        do_reset();
        collision = 1'b1;
        step();
        chk("hold_first_set", {31'b0, irq_cause[1]}, 32'h1);
        port_id = CP; out_port = 8'h02; write_strobe = 1'b1;
        step();
        write_strobe = 1'b0; port_id = 8'h00; out_port = 8'h00;
        chk("hold_cleared", {31'b0, irq_cause[1]}, 32'h0);
        for (int e = 3; e <= 20; e++) begin
            step();
            chk($sformatf("hold_e%0d_noretrig", e), {31'b0, irq_cause[1]}, 32'h0);
        end
        collision = 1'b0;
        step();
        chk("drop_no_set", {31'b0, irq_cause[1]}, 32'h0);
        collision = 1'b1;
        step();
        chk("reraise_set", {31'b0, irq_cause[1]}, 32'h1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
